// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs a single-outstanding
// request/grant/response handshake to imem and presents words to decode.
//
// state  | meaning
// IDLE   | one cycle after reset release before the first request
// REQ    | request driven at pc, waiting for grant
// WAIT   | granted, waiting for rvalid (timeout counter running)
// OUT    | word held for decode until accepted or redirected
// ERR    | fetch timed out; terminal until reset
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic        sclk_i,
  input  logic        srst_n_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i,
  output logic        fetch_err_o
);

  localparam logic [31:0] PC_RST  = RESET_PC & 32'hFFFF_FFFC;
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_ERR
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [7:0]  cnt_q;
  logic        kill_q;
  logic        valid_q;
  logic [31:0] inst_q;
  logic [31:0] ipc_q;
  logic        err_q;
  logic [31:0] tgt_pc_d;

  assign tgt_pc_d = redirect_pc_i & 32'hFFFF_FFFC;

  always_ff @(posedge sclk_i or negedge srst_n_i) begin
    if (!srst_n_i) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RST;
      cnt_q   <= 8'd0;
      kill_q  <= 1'b0;
      valid_q <= 1'b0;
      inst_q  <= 32'd0;
      ipc_q   <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (redirect_i) pc_q <= tgt_pc_d;
          state_q <= S_REQ;
        end
        S_REQ: begin
          if (redirect_i) pc_q <= tgt_pc_d;
          if (imem_gnt_i) begin
            // a redirect in the grant cycle means the granted fetch is stale
            state_q <= S_WAIT;
            cnt_q   <= 8'd0;
            kill_q  <= redirect_i;
          end
        end
        S_WAIT: begin
          if (redirect_i) pc_q <= tgt_pc_d;
          if (imem_rvalid_i) begin
            kill_q <= 1'b0;
            if (kill_q || redirect_i) begin
              state_q <= S_REQ;
            end else begin
              inst_q  <= imem_rdata_i;
              ipc_q   <= pc_q;
              valid_q <= 1'b1;
              state_q <= S_OUT;
            end
          end else if (cnt_q == TO_LAST) begin
            err_q   <= 1'b1;
            kill_q  <= 1'b0;
            state_q <= S_ERR;
          end else begin
            cnt_q <= cnt_q + 8'd1;
            if (redirect_i) kill_q <= 1'b1;
          end
        end
        S_OUT: begin
          // redirect wins over ready: the held word is treated as not consumed
          if (redirect_i) begin
            pc_q    <= tgt_pc_d;
            valid_q <= 1'b0;
            state_q <= S_REQ;
          end else if (inst_ready_i) begin
            pc_q    <= pc_q + 32'd4;
            valid_q <= 1'b0;
            state_q <= S_REQ;
          end
        end
        S_ERR: begin
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req_o   = (state_q == S_REQ);
  assign imem_addr_o  = pc_q;
  assign inst_valid_o = valid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = ipc_q;
  assign fetch_err_o  = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed cycle table, timeout/wrap sequences and a
// randomized run checked against a transaction-level PC/instruction model.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        ready;

  logic        req,   w_req;
  logic [31:0] addr,  w_addr;
  logic        valid, w_valid;
  logic [31:0] inst,  w_inst;
  logic [31:0] ipc,   w_ipc;
  logic        err,   w_err;

  int n_pass  = 0;
  int n_total = 0;

  fetch_ctrl dut (
    .sclk_i(clk), .srst_n_i(rst_n),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(req), .imem_addr_o(addr),
    .imem_gnt_i(gnt), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .inst_valid_o(valid), .inst_o(inst), .inst_pc_o(ipc),
    .inst_ready_i(ready), .fetch_err_o(err)
  );

  // Same stimulus, PC starting at the top of the address space to check wrap.
  fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYC(16)) dut_w (
    .sclk_i(clk), .srst_n_i(rst_n),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_gnt_i(gnt), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .inst_valid_o(w_valid), .inst_o(w_inst), .inst_pc_o(w_ipc),
    .inst_ready_i(ready), .fetch_err_o(w_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        g;
    logic        rv;
    logic [31:0] rd;
    logic        rdy;
    logic        rdr;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic g, logic rv, logic [31:0] rd, logic rdy, logic rdr,
                              logic [31:0] rpc, logic e_req, logic [31:0] e_addr,
                              logic e_valid, logic [31:0] e_inst, logic [31:0] e_ipc);
    vec_t v;
    v.g = g; v.rv = rv; v.rd = rd; v.rdy = rdy; v.rdr = rdr; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_inst = e_inst; v.e_ipc = e_ipc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0013_0000;
  endfunction

  task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic rdr, input logic [31:0] rpc);
    gnt = g; rvalid = rv; rdata = rd; ready = rdy; redirect = rdr; redirect_pc = rpc;
  endtask

  initial begin
    vec_t        v;
    logic        pend;
    int          lat;
    logic [31:0] paddr;
    logic [31:0] exp_pc;
    logic        prev_hold;
    logic [31:0] prev_inst, prev_ipc;
    int          consumed;

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    // cycle table: outputs expected before the row's inputs take effect
    vq.push_back(mk(0,0,32'h0,1,0,32'h0,     0,32'h0,  0,32'h0,32'h0));
    vq.push_back(mk(1,0,32'h0,1,0,32'h0,     1,32'h0,  0,32'h0,32'h0));
    vq.push_back(mk(0,1,32'h13,1,0,32'h0,    0,32'h0,  0,32'h0,32'h0));
    vq.push_back(mk(0,0,32'h0,1,0,32'h0,     0,32'h0,  1,32'h13,32'h0));
    vq.push_back(mk(1,0,32'h0,1,0,32'h0,     1,32'h4,  0,32'h13,32'h0));
    vq.push_back(mk(0,1,32'h13,1,0,32'h0,    0,32'h4,  0,32'h13,32'h0));
    vq.push_back(mk(0,0,32'h0,1,0,32'h0,     0,32'h4,  1,32'h13,32'h4));
    vq.push_back(mk(1,0,32'h0,0,0,32'h0,     1,32'h8,  0,32'h13,32'h4));
    vq.push_back(mk(0,1,32'hAAAA_0008,0,0,0, 0,32'h8,  0,32'h13,32'h4));
    for (int k = 0; k < 5; k++)
      vq.push_back(mk(0,0,32'h0,0,0,32'h0,   0,32'h8,  1,32'hAAAA_0008,32'h8));
    vq.push_back(mk(0,0,32'h0,1,0,32'h0,     0,32'h8,  1,32'hAAAA_0008,32'h8));
    vq.push_back(mk(1,0,32'h0,0,0,32'h0,     1,32'hC,  0,32'hAAAA_0008,32'h8));
    vq.push_back(mk(0,0,32'h0,0,1,32'h100,   0,32'hC,  0,32'hAAAA_0008,32'h8));
    vq.push_back(mk(0,1,32'hDEAD,0,0,32'h0,  0,32'h100,0,32'hAAAA_0008,32'h8));
    vq.push_back(mk(0,0,32'h0,0,0,32'h0,     1,32'h100,0,32'hAAAA_0008,32'h8));
    vq.push_back(mk(0,0,32'h0,0,1,32'h203,   1,32'h100,0,32'hAAAA_0008,32'h8));
    vq.push_back(mk(0,0,32'h0,0,0,32'h0,     1,32'h200,0,32'hAAAA_0008,32'h8));
    vq.push_back(mk(1,0,32'h0,0,0,32'h0,     1,32'h200,0,32'hAAAA_0008,32'h8));
    vq.push_back(mk(0,1,32'h1234_5678,0,0,0, 0,32'h200,0,32'hAAAA_0008,32'h8));
    vq.push_back(mk(0,0,32'h0,1,1,32'h40,    0,32'h200,1,32'h1234_5678,32'h200));
    vq.push_back(mk(1,0,32'h0,0,0,32'h0,     1,32'h40, 0,32'h1234_5678,32'h200));
    vq.push_back(mk(0,1,32'h55,0,0,32'h0,    0,32'h40, 0,32'h1234_5678,32'h200));
    vq.push_back(mk(0,0,32'h0,1,0,32'h0,     0,32'h40, 1,32'h55,32'h40));
    vq.push_back(mk(0,0,32'h0,0,0,32'h0,     1,32'h44, 0,32'h55,32'h40));

    repeat (3) @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_valid", valid, 0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_ipc", ipc, 32'h0);
    chk("rst_err", err, 0);
    chk("rst_addr_w", w_addr, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      chk($sformatf("t%0d_req", i), req, v.e_req);
      chk($sformatf("t%0d_addr", i), addr, v.e_addr);
      chk($sformatf("t%0d_valid", i), valid, v.e_valid);
      chk($sformatf("t%0d_inst", i), inst, v.e_inst);
      chk($sformatf("t%0d_ipc", i), ipc, v.e_ipc);
      chk($sformatf("t%0d_err", i), err, 0);
      if (i == 3) chk("wrap_ipc", w_ipc, 32'hFFFF_FFFC);
      if (i == 4) chk("wrap_addr", w_addr, 32'h0);
      drive(v.g, v.rv, v.rd, v.rdy, v.rdr, v.rpc);
      @(negedge clk);
    end

    // timeout: grant at 0x44 and never answer
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("to_wait%0d_err", k), err, 0);
      chk($sformatf("to_wait%0d_req", k), req, 0);
      @(negedge clk);
    end
    chk("to_err", err, 1);
    chk("to_err_w", w_err, 1);
    for (int k = 0; k < 8; k++) begin
      drive(1, 1, 32'h77, 1, 1, 32'h80);
      chk($sformatf("err%0d_req", k), req, 0);
      chk($sformatf("err%0d_valid", k), valid, 0);
      chk($sformatf("err%0d_err", k), err, 1);
      @(negedge clk);
    end

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rst2_err", err, 0);
    chk("rst2_addr", addr, 32'h0);
    chk("rst2_valid", valid, 0);
    chk("rst2_req", req, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized run against the transaction-level model
    pend = 0; lat = 0; paddr = 0; exp_pc = 32'h0;
    prev_hold = 0; prev_inst = 0; prev_ipc = 0; consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      if (prev_hold) begin
        chk("hold_valid", valid, 1);
        chk("hold_inst", inst, prev_inst);
        chk("hold_ipc", ipc, prev_ipc);
      end
      if (pend) chk("single_outstanding", req, 0);
      chk("no_err", err, 0);

      gnt = 0; rvalid = 0; rdata = 32'h0;
      if (pend) begin
        if (lat == 0) begin
          rvalid = 1; rdata = mem_word(paddr); pend = 0;
        end else begin
          lat--;
        end
      end else if (req && ($urandom_range(0, 1) == 1)) begin
        gnt = 1; pend = 1; paddr = addr; lat = $urandom_range(0, 4);
      end
      ready       = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = $urandom();

      if (redirect) begin
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (valid && ready) begin
        chk("rnd_pc", ipc, exp_pc);
        chk("rnd_inst", inst, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      prev_hold = valid && !ready && !redirect;
      prev_inst = inst;
      prev_ipc  = ipc;
      @(negedge clk);
    end
    chk("rnd_progress", (consumed >= 100) ? 32'd1 : 32'd0, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
